mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer sharing one single-ported synchronous `ram` instance between the pipeline's instruction-fetch port and its data port. It sits between `pipeline` and `ram` inside `raisin64`. It runs one memory transaction at a time. The data port has priority, and a bounded-streak rule prevents instruction-fetch starvation. Read data and handshakes are registered back to the requester.

## Interface
- `MEM_LATENCY`, default 1: edges from the RAM sampling `mem_cs` until `mem_din` is valid. Legal values are ≥1.
- `STARVE_LIMIT`, default 4: maximum number of consecutive data grants while an instruction request waits. Legal values are ≥1.

- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `i_addr_valid`, in, 1: instruction read request.
- `i_addr`, in, 64: instruction address.
- `i_data`, out, 64: instruction read data. Held until the next instruction access completes.
- `i_data_valid`, out, 1: one-cycle completion pulse for the instruction port.
- `d_addr_valid`, in, 1: data request.
- `d_write`, in, 1: 1 means write, 0 means read. Qualified by `d_addr_valid`.
- `d_addr`, in, 64: data address.
- `d_wdata`, in, 64: write data.
- `d_rdata`, out, 64: data read data. Held until the next data read completes; writes leave it unchanged.
- `d_ready`, out, 1: one-cycle completion pulse for the data port, for both reads and writes.
- `mem_cs`, out, 1: RAM chip select. Registered.
- `mem_we`, out, 1: RAM write enable. Registered; only ever high together with `mem_cs`.
- `mem_addr`, out, 64: RAM address. Registered; holds its value after the access.
- `mem_dout`, out, 64: RAM write data. Registered.
- `mem_din`, in, 64: RAM read data.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
**Reset values:** all outputs are 0, state is IDLE, and the streak counter is 0. Reset mid-transaction abandons the access immediately. No ack is issued afterwards, and `mem_cs` drops asynchronously.

**States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:** at an edge with any request valid, perform a grant.
  - Latch the owner, the address, write data, and `mem_we = d_write` for a data owner, 0 for an instruction owner.
  - Go to ISSUE. `mem_cs` is 1 during ISSUE only.
- **ISSUE → WAIT:** on the next edge. Load the wait counter with `MEM_LATENCY-1`.
- **WAIT:**
  - If the counter is 0, capture `mem_din` into the owner's read-data register at that edge. Skip the capture for writes. Go to RESP.
  - Otherwise decrement the counter.
- **RESP:** the owner's ack (`i_data_valid` or `d_ready`) is 1 for exactly this cycle. New requests are not sampled in RESP. Go to IDLE on the next edge.

**Arbitration** is evaluated only in IDLE.
- Only one port requesting: grant it.
- Both requesting: grant data, unless the streak counter equals `STARVE_LIMIT`, in which case grant instruction.
- Streak counter updates at each grant:
  - Data grant with an instruction request also valid: increment, saturating at `STARVE_LIMIT`.
  - Any instruction grant: clear to 0.
  - Data grant with no instruction request: clear to 0.

**Requester protocol:**
- Hold the valid, address, and write fields stable from assertion until the ack cycle.
- Deassert at or after the ack edge.
- Dropping a request early is a protocol violation. The arbiter still completes and acks the access.

**Other rules:**
- Only the owner's read-data register ever changes.
- Both ack outputs are never high in the same cycle.
- The counter width is `$clog2(MEM_LATENCY)`, with a minimum of 1 bit.

## Timing
- Grant edge E0: `mem_cs` is high from E0 to E1. The RAM samples it at E1.
- Capture edge: E1+`MEM_LATENCY`.
- Ack: high in the cycle following the capture edge.
- Request-to-ack latency: `MEM_LATENCY`+2 edges after the grant edge.
- Back-to-back grants are `MEM_LATENCY`+3 edges apart. With the default latency, a grant is possible every 4 cycles.
- A request arriving during `busy` waits; no request is lost.

## Test plan
- **Instruction read:** preload RAM[0x8]=0x1122334455667788, `MEM_LATENCY`=1, assert `i_addr_valid` with `i_addr`=0x8.
  - `mem_cs` is high for 1 cycle.
  - `i_data_valid` pulses 3 edges after the grant.
  - `i_data`=0x1122334455667788.
  - `d_ready` stays 0.
- **Data write then read:** write 0xDEADBEEF to 0x10, then read 0x10.
  - First access: `mem_we`=1 with `mem_cs`; `d_ready` pulses; `d_rdata` is unchanged.
  - Second access: `d_rdata`=0xDEADBEEF.
- **Contention:** hold both requests continuously with `STARVE_LIMIT`=4.
  - Grant sequence is D,D,D,D,I repeating.
  - Acks never overlap.
- **Latency:** `MEM_LATENCY`=3, single instruction read.
  - Ack arrives 5 edges after the grant.
  - The captured value is `mem_din` sampled at E4.
- **Reset:** assert `rst_n`=0 during WAIT.
  - All outputs are 0 immediately; no ack follows.
  - After release, a fresh request completes normally with the streak counter at 0.
- **Early request drop:** deassert `i_addr_valid` during ISSUE.
  - The access completes and `i_data_valid` still pulses once.
  - No second grant occurs.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported synchronous RAM between the instruction-fetch
// port and the data port. One access at a time; data has priority, with a bounded
// streak of data grants before a waiting instruction fetch is served.
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_addr_valid,
    input  logic [63:0] i_addr,
    output logic [63:0] i_data,
    output logic        i_data_valid,
    input  logic        d_addr_valid,
    input  logic        d_write,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_ready,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_dout,
    input  logic [63:0] mem_din,
    output logic        busy
);

    localparam int unsigned CntW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0]    CntLoad   = CntW'(MEM_LATENCY - 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic                data_owner_q, data_owner_d;
    logic                write_q, write_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic                mem_cs_q, mem_cs_d;
    logic                mem_we_q, mem_we_d;
    logic [63:0]         mem_addr_q, mem_addr_d;
    logic [63:0]         mem_dout_q, mem_dout_d;
    logic [63:0]         i_data_q, i_data_d;
    logic [63:0]         d_rdata_q, d_rdata_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                grant_data;

    // Data wins unless an instruction fetch has already been passed over too often.
    assign grant_data = d_addr_valid && !(i_addr_valid && (streak_q == StreakMax));

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            data_owner_q <= 1'b0;
            write_q      <= 1'b0;
            cnt_q        <= '0;
            streak_q     <= '0;
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_dout_q   <= '0;
            i_data_q     <= '0;
            d_rdata_q    <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_owner_q <= data_owner_d;
            write_q      <= write_d;
            cnt_q        <= cnt_d;
            streak_q     <= streak_d;
            mem_cs_q     <= mem_cs_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_dout_q   <= mem_dout_d;
            i_data_q     <= i_data_d;
            d_rdata_q    <= d_rdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
        end
    end

    // Next-state: grant in IDLE, one-cycle chip select, latency countdown, one-cycle ack.
    always_comb begin
        state_d      = state_q;
        data_owner_d = data_owner_q;
        write_d      = write_q;
        cnt_d        = cnt_q;
        streak_d     = streak_q;
        mem_cs_d     = mem_cs_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_dout_d   = mem_dout_q;
        i_data_d     = i_data_q;
        d_rdata_d    = d_rdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_addr_valid || d_addr_valid) begin
                    state_d      = StIssue;
                    data_owner_d = grant_data;
                    mem_cs_d     = 1'b1;
                    if (grant_data) begin
                        write_d    = d_write;
                        mem_we_d   = d_write;
                        mem_addr_d = d_addr;
                        mem_dout_d = d_wdata;
                        // Streak only grows while a fetch is actually being passed over.
                        if (!i_addr_valid) begin
                            streak_d = '0;
                        end else if (streak_q != StreakMax) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        write_d    = 1'b0;
                        mem_we_d   = 1'b0;
                        mem_addr_d = i_addr;
                        streak_d   = '0;
                    end
                end
            end
            StIssue: begin
                state_d  = StWait;
                cnt_d    = CntLoad;
                mem_cs_d = 1'b0;
                mem_we_d = 1'b0;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    if (data_owner_q) begin
                        d_ack_d = 1'b1;
                        if (!write_q) begin
                            d_rdata_d = mem_din;
                        end
                    end else begin
                        i_ack_d  = 1'b1;
                        i_data_d = mem_din;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign i_data       = i_data_q;
    assign i_data_valid = i_ack_q;
    assign d_rdata      = d_rdata_q;
    assign d_ready      = d_ack_q;
    assign mem_cs       = mem_cs_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_dout     = mem_dout_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized two-port traffic, checked
// by a timeline-level reference model and per-port response scoreboards.
module tb_mem_arbiter;

    localparam int Lat   = 3;
    localparam int Limit = 4;

    logic        clk;
    logic        rst_n;
    logic        i_addr_valid;
    logic [63:0] i_addr;
    logic [63:0] i_data;
    logic        i_data_valid;
    logic        d_addr_valid;
    logic        d_write;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_ready;
    logic        mem_cs;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_dout;
    logic [63:0] mem_din;
    logic        busy;

    mem_arbiter #(
        .MEM_LATENCY (Lat),
        .STARVE_LIMIT(Limit)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_addr_valid(i_addr_valid),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .i_data_valid(i_data_valid),
        .d_addr_valid(d_addr_valid),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ready     (d_ready),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .mem_din     (mem_din),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void check(input bit ok, input string name,
                                  input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [63:0] init_word(input int k);
        if (k == 1) return 64'h1122334455667788;
        return (64'h9E3779B97F4A7C15 * 64'(k + 3)) ^ 64'h0F0F_1234_5678_ABCD;
    endfunction

    // ---------------- RAM environment: read data valid MEM_LATENCY edges after cs ----------
    logic [63:0] ram [16];
    logic [63:0] rd_pipe [Lat];
    assign mem_din = rd_pipe[Lat-1];

    initial begin
        for (int k = 0; k < 16; k++) ram[k] = init_word(k);
        forever begin
            @(posedge clk);
            for (int k = Lat - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
            // Junk outside the valid slot exposes an off-by-one capture.
            if (mem_cs && !mem_we) rd_pipe[0] <= ram[mem_addr[6:3]];
            else                   rd_pipe[0] <= {$urandom, $urandom};
            if (mem_cs && mem_we)  ram[mem_addr[6:3]] <= mem_dout;
        end
    end

    // ---------------- Reference model: grant timeline and arbitration rule -----------------
    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } grant_t;

    grant_t gq[$];
    int     n      = 0;
    int     g_last = -1000;
    bit     g_data = 1'b0;
    int     streak = 0;
    bit     exp_cs = 1'b0, exp_busy = 1'b0, exp_iack = 1'b0, exp_dack = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                n = 0; g_last = -1000; streak = 0;
                exp_cs = 0; exp_busy = 0; exp_iack = 0; exp_dack = 0;
                gq.delete();
            end else begin
                n++;
                // A new grant is possible MEM_LATENCY+3 edges after the previous one.
                if (n >= g_last + Lat + 3 && (i_addr_valid || d_addr_valid)) begin
                    g_data = d_addr_valid && !(i_addr_valid && streak == Limit);
                    if (g_data && i_addr_valid) streak = (streak < Limit) ? streak + 1 : Limit;
                    else                        streak = 0;
                    g_last = n;
                    gq.push_back('{is_d: g_data, we: g_data ? d_write : 1'b0,
                                   addr: g_data ? d_addr : i_addr, wdata: d_wdata});
                end
                exp_cs   = (n == g_last);
                exp_busy = (n >= g_last) && (n <= g_last + Lat + 1);
                exp_iack = (n == g_last + Lat + 1) && !g_data;
                exp_dack = (n == g_last + Lat + 1) && g_data;
            end
        end
    end

    // ---------------- Scoreboards and monitor ---------------------------------------------
    logic [63:0] i_exp_q[$];
    logic [63:0] d_exp_q[$];
    logic [63:0] ref_mem [16];
    logic [63:0] d_last = '0;
    logic [63:0] i_hold = '0, d_hold = '0;
    int          cyc = 0, cs_cyc = 0, iack_cyc = 0, gcount = 0;
    bit          obs_en = 1'b0;
    bit          obs_q[$];

    initial begin
        grant_t      g;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                i_hold = '0;
                d_hold = '0;
            end
            check(mem_cs == exp_cs, "mem_cs", 64'(mem_cs), 64'(exp_cs));
            check(busy == exp_busy, "busy", 64'(busy), 64'(exp_busy));
            check(i_data_valid == exp_iack, "i_data_valid", 64'(i_data_valid), 64'(exp_iack));
            check(d_ready == exp_dack, "d_ready", 64'(d_ready), 64'(exp_dack));
            check(!(mem_we && !mem_cs), "we_without_cs", 64'(mem_we), 64'(mem_cs));
            check(!(i_data_valid && d_ready), "ack_overlap", 64'(i_data_valid), 64'(0));
            if (mem_cs) begin
                gcount++;
                cs_cyc = cyc;
                if (obs_en) obs_q.push_back(mem_addr >= 64'h40);
                if (gq.size() == 0) begin
                    check(1'b0, "grant_unexpected", mem_addr, 64'(0));
                end else begin
                    g = gq.pop_front();
                    check(mem_addr == g.addr, "grant_addr", mem_addr, g.addr);
                    check(mem_we == g.we, "grant_we", 64'(mem_we), 64'(g.we));
                    if (g.we) check(mem_dout == g.wdata, "grant_wdata", mem_dout, g.wdata);
                end
            end
            if (i_data_valid) begin
                iack_cyc = cyc;
                if (i_exp_q.size() == 0) begin
                    check(1'b0, "i_ack_unexpected", i_data, 64'(0));
                end else begin
                    e = i_exp_q.pop_front();
                    check(i_data == e, "i_data", i_data, e);
                    i_hold = e;
                end
            end else begin
                check(i_data == i_hold, "i_data_hold", i_data, i_hold);
            end
            if (d_ready) begin
                if (d_exp_q.size() == 0) begin
                    check(1'b0, "d_ack_unexpected", d_rdata, 64'(0));
                end else begin
                    e = d_exp_q.pop_front();
                    check(d_rdata == e, "d_rdata", d_rdata, e);
                    d_hold = e;
                end
            end else begin
                check(d_rdata == d_hold, "d_rdata_hold", d_rdata, d_hold);
            end
        end
    end

    // ---------------- Requester drivers (called at posedge+1) ----------------------------
    task automatic i_txn(input logic [63:0] addr, input bit early);
        bit got = 1'b0;
        i_addr       = addr;
        i_addr_valid = 1'b1;
        i_exp_q.push_back(ref_mem[addr[6:3]]);
        for (int w = 0; w < 80 && !got; w++) begin
            @(negedge clk);
            if (early && mem_cs) i_addr_valid = 1'b0;
            if (i_data_valid) got = 1'b1;
        end
        check(got, "i_ack_timeout", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        i_addr_valid = 1'b0;
    endtask

    task automatic d_txn(input bit we, input logic [63:0] addr, input logic [63:0] wdata);
        bit got = 1'b0;
        d_write      = we;
        d_addr       = addr;
        d_wdata      = wdata;
        d_addr_valid = 1'b1;
        if (we) begin
            d_exp_q.push_back(d_last);
            ref_mem[addr[6:3]] = wdata;
        end else begin
            d_last = ref_mem[addr[6:3]];
            d_exp_q.push_back(d_last);
        end
        for (int w = 0; w < 80 && !got; w++) begin
            @(negedge clk);
            if (d_ready) got = 1'b1;
        end
        check(got, "d_ack_timeout", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        d_addr_valid = 1'b0;
    endtask

    task automatic i_stream(input int cnt);
        for (int k = 0; k < cnt; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            i_txn(64'($urandom_range(0, 7)) << 3, 1'b0);
        end
    endtask

    task automatic d_stream(input int cnt);
        for (int k = 0; k < cnt; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            d_txn(1'($urandom_range(0, 1)), 64'(8 + $urandom_range(0, 7)) << 3,
                  {$urandom, $urandom});
        end
    endtask

    // ---------------- Directed and random sequences ---------------------------------------
    initial begin
        int g0;
        bit any;
        for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);
        rst_n = 1'b0;
        i_addr_valid = 1'b0; i_addr = '0;
        d_addr_valid = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single instruction read: value and grant-to-ack latency.
        i_txn(64'h8, 1'b0);
        check(i_data == 64'h1122334455667788, "i_read_value", i_data, 64'h1122334455667788);
        check(iack_cyc - cs_cyc + 1 == Lat + 2, "i_ack_latency_edges",
              64'(iack_cyc - cs_cyc + 1), 64'(Lat + 2));

        // Data write leaves d_rdata alone; read back returns the written word.
        d_txn(1'b1, 64'h10, 64'hDEADBEEF);
        check(d_rdata == 64'h0, "d_rdata_after_write", d_rdata, 64'h0);
        d_txn(1'b0, 64'h10, 64'h0);
        check(d_rdata == 64'hDEADBEEF, "d_read_back", d_rdata, 64'hDEADBEEF);

        // Instruction request dropped during ISSUE still completes once, no regrant.
        g0 = gcount;
        i_txn(64'h18, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check(gcount - g0 == 1, "early_drop_grants", 64'(gcount - g0), 64'(1));

        // Reset during WAIT of the third contended data grant (streak built up to 3).
        for (int k = 0; k < 8; k++) d_exp_q.push_back(ref_mem[9]);
        i_addr = 64'h08; i_addr_valid = 1'b1;
        d_write = 1'b0; d_addr = 64'h48; d_addr_valid = 1'b1;
        g0 = gcount;
        for (int w = 0; w < 100 && gcount < g0 + 3; w++) begin
            @(negedge clk);
            #1;
        end
        check(gcount == g0 + 3, "reset_setup_grants", 64'(gcount - g0), 64'(3));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        any = |{i_data, i_data_valid, d_rdata, d_ready, mem_cs, mem_we, mem_addr, mem_dout,
                busy};
        check(!any, "async_reset_outputs_zero", 64'(any), 64'(0));
        i_addr_valid = 1'b0;
        d_addr_valid = 1'b0;
        i_exp_q.delete();
        d_exp_q.delete();
        d_last = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous contention after reset: streak restarts from 0.
        obs_q.delete();
        obs_en = 1'b1;
        fork
            begin
                i_txn(64'h08, 1'b0);
                i_txn(64'h08, 1'b0);
            end
            begin
                for (int k = 0; k < 9; k++) d_txn(1'b0, 64'h48, 64'h0);
            end
        join
        obs_en = 1'b0;
        check(obs_q.size() == 11, "contention_grant_count", 64'(obs_q.size()), 64'(11));
        if (obs_q.size() >= 10) begin
            for (int k = 0; k < 10; k++) begin
                check(obs_q[k] == ((k % 5) != 4), "contention_order",
                      64'(obs_q[k]), 64'((k % 5) != 4));
            end
        end

        // Randomized concurrent traffic on disjoint address regions.
        fork
            i_stream(30);
            d_stream(30);
        join
        repeat (10) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
